dual_slope_ctrl: RTL

DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

---
 rtl/ds_adc_pkg.sv | 16 +
 rtl/ds_phase_counter.sv | 30 +++
 rtl/dual_slope_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ds_adc_pkg.sv
// Shared types and default parameters for the dual-slope ADC controller.
package ds_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO,
        ST_INTEG,
        ST_DEINT,
        ST_DONE
    } dsState_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_COUNT = 10;
    localparam int DEF_ZERO_CYC  = 2;

endpackage

// File: rtl/ds_phase_counter.sv
// Phase counter with synchronous clear, count enable and a terminal-count flag.
module ds_phase_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstN,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_tcVal,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable so a state entry always starts the phase at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_tcVal);

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencing FSM: auto-zero, integrate, deintegrate, report.
// Auto-zero phase is present only when DS_AUTOZERO_EN is defined.
module dual_slope_ctrl
    import ds_adc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT,
    parameter int ZERO_CYC  = DEF_ZERO_CYC
) (
    input  logic             clk,
    input  logic             rst_s_n,
    input  logic             start,
    input  logic             comp,
    output logic             sw_zero,
    output logic             sw_vin,
    output logic             sw_vref,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] LP_MAX_TC  = WIDTH'(MAX_COUNT - 1);
    localparam logic [WIDTH-1:0] LP_ZERO_TC = WIDTH'(ZERO_CYC - 1);

    dsState_t         r_state;
    dsState_t         w_nextState;
    logic             w_cntClr;
    logic             w_cntEn;
    logic [WIDTH-1:0] w_tcVal;
    logic [WIDTH-1:0] w_count;
    logic             w_tc;
    logic             w_latch;
    logic             w_ovfNext;
    logic             r_swVin;
    logic             r_swVref;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    assign w_tcVal  = (r_state == ST_ZERO) ? LP_ZERO_TC : LP_MAX_TC;
    assign w_cntClr = (w_nextState != r_state);

    ds_phase_counter #(
        .WIDTH (WIDTH)
    ) u_phaseCnt (
        .i_clk   (clk),
        .i_rstN  (rst_s_n),
        .i_clr   (w_cntClr),
        .i_en    (w_cntEn),
        .i_tcVal (w_tcVal),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_nextState = r_state;
        w_cntEn     = 1'b0;
        w_latch     = 1'b0;
        w_ovfNext   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef DS_AUTOZERO_EN
                    w_nextState = ST_ZERO;
`else
                    w_nextState = ST_INTEG;
`endif
                end
            end
`ifdef DS_AUTOZERO_EN
            ST_ZERO: begin
                w_cntEn = 1'b1;
                if (w_tc) begin
                    w_nextState = ST_INTEG;
                end
            end
`endif
            ST_INTEG: begin
                w_cntEn = 1'b1;
                if (w_tc) begin
                    w_nextState = ST_DEINT;
                end
            end
            ST_DEINT: begin
                // At saturation the count already equals MAX_COUNT-1, so both exits latch w_count.
                if (!comp) begin
                    w_nextState = ST_DONE;
                    w_latch     = 1'b1;
                end else if (w_tc) begin
                    w_nextState = ST_DONE;
                    w_latch     = 1'b1;
                    w_ovfNext   = 1'b1;
                end else begin
                    w_cntEn = 1'b1;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the next state so they are registered yet aligned with the state.
    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            r_state  <= ST_IDLE;
            r_swVin  <= 1'b0;
            r_swVref <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_swVin  <= (w_nextState == ST_INTEG);
            r_swVref <= (w_nextState == ST_DEINT);
            r_busy   <= (w_nextState != ST_IDLE);
            r_valid  <= (w_nextState == ST_DONE);
            if (w_latch) begin
                r_result <= w_count;
                r_ovf    <= w_ovfNext;
            end
        end
    end

`ifdef DS_AUTOZERO_EN
    logic r_swZero;

    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            r_swZero <= 1'b0;
        end else begin
            r_swZero <= (w_nextState == ST_ZERO);
        end
    end

    assign sw_zero = r_swZero;
`else
    assign sw_zero = 1'b0;
`endif

    assign sw_vin  = r_swVin;
    assign sw_vref = r_swVref;
    assign busy    = r_busy;
    assign valid   = r_valid;
    assign result  = r_result;
    assign ovf     = r_ovf;

endmodule
